sr_write_sequencer: RTL

Sequences one complete shift-register write/readback transaction for the configuration chain on the test chip. It accepts a WIDTH-bit parallel word through a req/busy handshake and owns the free-running divider counter. It produces the start, start_tmp, count and counter signals that the shift-register clock generator consumes. It also drives serial data MSB-first, pulses the chain's load strobe, and optionally captures the serial readback word.

---
 rtl/sr_write_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sr_write_sequencer.sv
// Shift-register write/readback sequencer: owns the divider counter and drives start/count/sdout/load.
// Optional readback capture of sdin into dout is enabled with `define SR_READBACK_EN.
module sr_write_sequencer #(
  parameter int WIDTH       = 170,
  parameter int CNT_WIDTH   = 8,
  parameter int DIV_WIDTH   = 6,
  parameter int COUNT_WIDTH = 64
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   req,
  input  logic [WIDTH-1:0]       din,
  input  logic [DIV_WIDTH-1:0]   div,
  output logic                   busy,
  output logic                   start,
  output logic                   start_tmp,
  output logic [CNT_WIDTH-1:0]   count,
  output logic [COUNT_WIDTH-1:0] counter,
  output logic                   sdout,
  output logic                   load,
  input  logic                   sdin,
  output logic [WIDTH-1:0]       dout,
  output logic                   done
);

  typedef enum logic [2:0] {IDLE, ARM, SHIFT, LOAD, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_PRE  = CNT_WIDTH'(WIDTH);

  state_t                 state, state_nxt;
  logic                   busy_nxt, start_nxt, start_tmp_nxt, sdout_nxt, load_nxt, done_nxt;
  logic [CNT_WIDTH-1:0]   count_nxt;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]       shreg;
  logic                   capture, shift_en, tick;
  logic [COUNT_WIDTH-1:0] mask;

  // A division exponent of 0 behaves as 1, so the shortest divided period is 2 cycles.
  function automatic logic [COUNT_WIDTH-1:0] tick_mask(input logic [DIV_WIDTH-1:0] dv);
    logic [DIV_WIDTH-1:0] d;
    d = (dv == '0) ? DIV_WIDTH'(1) : dv;
    return (COUNT_WIDTH'(1) << d) - COUNT_WIDTH'(1);
  endfunction

  assign mask = tick_mask(div_q);
  assign tick = ((counter & mask) == mask);

  always_comb begin
    state_nxt     = state;
    busy_nxt      = busy;
    start_nxt     = start;
    start_tmp_nxt = start_tmp;
    count_nxt     = count;
    sdout_nxt     = sdout;
    load_nxt      = load;
    done_nxt      = 1'b0;
    capture       = 1'b0;
    shift_en      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          capture   = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (tick) begin
          start_nxt = 1'b1;
          sdout_nxt = shreg[WIDTH-1];
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          start_nxt     = 1'b0;
          start_tmp_nxt = start;
          count_nxt     = count + CNT_WIDTH'(1);
          sdout_nxt     = shreg[WIDTH-2];
          shift_en      = 1'b1;
          if (count == CNT_PRE) begin
            load_nxt  = 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        // Closing tick of the load period wraps up the transaction in one edge.
        if (tick) begin
          load_nxt  = 1'b0;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          count_nxt = '0;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      start     <= 1'b0;
      start_tmp <= 1'b0;
      count     <= '0;
      counter   <= '0;
      sdout     <= 1'b0;
      load      <= 1'b0;
      done      <= 1'b0;
      div_q     <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= busy_nxt;
      start     <= start_nxt;
      start_tmp <= start_tmp_nxt;
      count     <= count_nxt;
      counter   <= counter + COUNT_WIDTH'(1);
      sdout     <= sdout_nxt;
      load      <= load_nxt;
      done      <= done_nxt;
      if (capture) div_q <= div;
    end
  end

  always_ff @(posedge clk_in) begin
    if (capture) shreg <= din;
    else if (shift_en) shreg <= {shreg[WIDTH-2:0], 1'b0};
  end

`ifdef SR_READBACK_EN
  logic [WIDTH-1:0] rb;

  always_ff @(posedge clk_in) begin
    if (shift_en) rb <= {rb[WIDTH-2:0], sdin};
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) dout <= '0;
    else if (done_nxt) dout <= rb;
  end
`else
  logic unused_sdin;
  assign unused_sdin = sdin;
  assign dout        = '0;
`endif

endmodule
